// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// FUNCT3 access codes and the access-size decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_FIN
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes; FUNCT3[1:0] encodes log2 of the size.
  function automatic logic [3:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 4'd1;
      2'b01:   size_of = 4'd2;
      2'b10:   size_of = 4'd4;
      default: size_of = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane datapath: extracts and extends a load from a memory
// doubleword, and merges store bytes into a doubleword for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);

  logic [63:0] shifted;
  int          lo;
  int          hi;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data = {56'd0, shifted[7:0]};
      F3_HU:   load_data = {48'd0, shifted[15:0]};
      F3_WU:   load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Only bytes offset..offset+size-1 take store data; the rest keep the old word.
  always_comb begin
    lo         = int'(offset);
    hi         = lo + int'(size_of(funct3));
    store_data = word;
    for (int i = 0; i < 8; i++) begin
      if (i >= lo && i < hi) begin
        store_data[8*i +: 8] = wdata[8*(i-lo) +: 8];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store engine between the datapath and a 64-bit data memory;
// sub-doubleword stores are performed as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_store,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [63:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  localparam logic [7:0] LAT_M1 = 8'(RD_LAT - 1);

  lsu_state_t    state;
  logic          store_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;
  logic [7:0]    cnt;

  logic [2:0]    align_mask;
  logic          illegal;
  logic [63:0]   load_data;
  logic [63:0]   store_data;

  always_comb begin
    align_mask = size_of(f3_q)[2:0] - 3'd1;
    illegal    = ((addr_q[2:0] & align_mask) != 3'd0)
               || (f3_q == 3'b111)
               || (store_q && f3_q[2]);
  end

  assign mem_addr = {addr_q[AW-1:3], 3'b000};

  // The lane datapath works on the live read data so the extracted load and
  // the merged store word are registered on the same edge that ends the wait.
  lsu_lane_align u_align (
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .offset     (addr_q[2:0]),
    .funct3     (f3_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      store_q   <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 64'd0;
      cnt       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 64'd0;
      mem_wr    <= 1'b0;
      mem_wdata <= 64'd0;
    end else begin
      done   <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            store_q <= is_store;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (illegal) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_FIN;
          end else if (store_q && f3_q == F3_D) begin
            mem_wdata <= wdata_q;
            mem_wr    <= 1'b1;
            state     <= S_WRITE;
          end else begin
            state <= S_READ;
          end
        end
        S_READ: begin
          cnt   <= LAT_M1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 8'd0) begin
            if (store_q) begin
              mem_wdata <= store_data;
              mem_wr    <= 1'b1;
              state     <= S_WRITE;
            end else begin
              rdata <= load_data;
              done  <= 1'b1;
              state <= S_FIN;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_WRITE: begin
          done  <= 1'b1;
          state <= S_FIN;
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: two load_store_unit instances (read latency 1 and 3)
// share one request stream and are compared against a byte-level memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;

  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];
  logic [63:0] rdata     [2];
  logic [63:0] maddr     [2];
  logic        mwr       [2];
  logic [63:0] mwdata    [2];
  logic [63:0] mrdata    [2];

  logic [63:0] mem       [2][32];
  logic [63:0] refmem    [32];
  logic [63:0] pipe0;
  logic [63:0] pipe1     [3];
  logic [63:0] lastRdata [2];

  int nChecks;
  int nFails;

  load_store_unit #(.RD_LAT(1), .AW(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .rdata(rdata[0]),
    .mem_addr(maddr[0]), .mem_wr(mwr[0]), .mem_wdata(mwdata[0]),
    .mem_rdata(mrdata[0])
  );

  load_store_unit #(.RD_LAT(3), .AW(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .rdata(rdata[1]),
    .mem_addr(maddr[1]), .mem_wr(mwr[1]), .mem_wdata(mwdata[1]),
    .mem_rdata(mrdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories with a registered read path of 1 and 3 cycles respectively.
  always @(posedge clk) begin
    pipe0    <= mem[0][maddr[0][7:3]];
    pipe1[0] <= mem[1][maddr[1][7:3]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
    if (mwr[0]) mem[0][maddr[0][7:3]] = mwdata[0];
    if (mwr[1]) mem[1][maddr[1][7:3]] = mwdata[1];
  end

  assign mrdata[0] = pipe0;
  assign mrdata[1] = pipe1[2];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%016h required 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic setMem(input int idx, input logic [63:0] val);
    mem[0][idx] = val;
    mem[1][idx] = val;
    refmem[idx] = val;
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [63:0] a,
                               input logic [63:0] wd, input logic repulse);
    int          size;
    int          off;
    int          idx;
    bit          legal;
    logic [63:0] old;
    logic [63:0] mask;
    logic [63:0] expLoad;
    logic [63:0] expWord;
    int          expLat [2];
    int          lat    [2];
    int          dcnt   [2];
    int          wcnt   [2];
    logic        errCap [2];
    logic        busy1  [2];

    size  = 1 << f3[1:0];
    off   = int'(a[2:0]);
    idx   = int'(a[7:3]);
    legal = (f3 != 3'b111) && !(st && f3[2]) && ((off % size) == 0);
    old   = refmem[idx];
    mask  = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (8*size)) - 64'h1);

    expLoad = (old >> (8*off)) & mask;
    if (!f3[2] && expLoad[8*size-1]) expLoad = expLoad | ~mask;
    expWord = (old & ~(mask << (8*off))) | ((wd & mask) << (8*off));

    for (int k = 0; k < 2; k++) begin
      int L;
      L = (k == 0) ? 1 : 3;
      if (!legal)                   expLat[k] = 2;
      else if (st && f3 == 3'b011)  expLat[k] = 3;
      else if (st)                  expLat[k] = 4 + L;
      else                          expLat[k] = 3 + L;
      lat[k] = 0; dcnt[k] = 0; wcnt[k] = 0; errCap[k] = 1'b0; busy1[k] = 1'b0;
    end

    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (n == 1) busy1[k] = busy[k];
        if (mwr[k]) wcnt[k]++;
        if (done[k]) begin
          dcnt[k]++;
          if (lat[k] == 0) begin
            lat[k]       = n;
            errCap[k]    = err[k];
            lastRdata[k] = rdata[k];
          end
        end
      end
      if (n == 1) begin
        start = repulse;
        wdata = ~wd;
      end
      if (n == 2) start = 1'b0;
    end

    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("latency d%0d a=%h f3=%0d st=%0d", k, a, f3, st), 64'(lat[k]), 64'(expLat[k]));
      checkOutput($sformatf("done_count d%0d", k), 64'(dcnt[k]), 64'd1);
      checkOutput($sformatf("err d%0d a=%h f3=%0d st=%0d", k, a, f3, st), 64'(errCap[k]), 64'(!legal));
      checkOutput($sformatf("busy_after_start d%0d", k), 64'(busy1[k]), 64'd1);
      checkOutput($sformatf("busy_idle d%0d", k), 64'(busy[k]), 64'd0);
      checkOutput($sformatf("write_count d%0d", k), 64'(wcnt[k]), 64'(legal && st));
      if (legal && !st)
        checkOutput($sformatf("rdata d%0d a=%h f3=%0d", k, a, f3), lastRdata[k], expLoad);
      checkOutput($sformatf("mem_word d%0d idx=%0d", k, idx), mem[k][idx], (legal && st) ? expWord : old);
    end
    if (legal && st) refmem[idx] = expWord;
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [63:0] ra;
    int          sz;
    bit          seen;

    nChecks = 0; nFails = 0;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 64'd0; wdata = 64'd0;
    for (int i = 0; i < 32; i++) setMem(i, {$urandom, $urandom});

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("reset_busy d%0d", k), 64'(busy[k]), 64'd0);
      checkOutput($sformatf("reset_done d%0d", k), 64'(done[k]), 64'd0);
      checkOutput($sformatf("reset_err d%0d", k), 64'(err[k]), 64'd0);
      checkOutput($sformatf("reset_rdata d%0d", k), rdata[k], 64'd0);
      checkOutput($sformatf("reset_mem_wr d%0d", k), 64'(mwr[k]), 64'd0);
      checkOutput($sformatf("reset_mem_addr d%0d", k), maddr[k], 64'd0);
      checkOutput($sformatf("reset_mem_wdata d%0d", k), mwdata[k], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    setMem(2, 64'h1122334455667788);
    applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, 1'b0);
    checkOutput("ld_0x10", lastRdata[0], 64'h1122334455667788);
    applyStimulus(1'b0, 3'b000, 64'h13, 64'd0, 1'b0);
    checkOutput("lb_0x13", lastRdata[1], 64'h0000000000000055);
    setMem(2, 64'h11223344F0667788);
    applyStimulus(1'b0, 3'b000, 64'h13, 64'd0, 1'b0);
    checkOutput("lb_neg", lastRdata[0], 64'hFFFFFFFFFFFFFFF0);
    applyStimulus(1'b0, 3'b100, 64'h13, 64'd0, 1'b0);
    checkOutput("lbu", lastRdata[0], 64'h00000000000000F0);
    setMem(3, 64'd0);
    applyStimulus(1'b1, 3'b001, 64'h1A, 64'hABCD, 1'b0);
    checkOutput("sh_0x1A", mem[0][3], 64'h00000000ABCD0000);
    applyStimulus(1'b0, 3'b010, 64'h16, 64'd0, 1'b0);
    applyStimulus(1'b1, 3'b100, 64'h18, 64'h55, 1'b0);
    applyStimulus(1'b1, 3'b011, 64'h28, 64'hDEADBEEFCAFEF00D, 1'b0);
    applyStimulus(1'b1, 3'b001, 64'h34, 64'h1234, 1'b1);
    applyStimulus(1'b0, 3'b110, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0);

    // Reset during the write cycle of a word store.
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 64'h44; wdata = 64'h0BADF00D;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (mwr[0]) seen = 1'b1;
      else @(negedge clk);
    end
    checkOutput("rst_write_reached", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_mid_mem_wr d%0d", k), 64'(mwr[k]), 64'd0);
      checkOutput($sformatf("rst_mid_busy d%0d", k), 64'(busy[k]), 64'd0);
      checkOutput($sformatf("rst_mid_rdata d%0d", k), rdata[k], 64'd0);
      checkOutput($sformatf("rst_mid_mem_addr d%0d", k), maddr[k], 64'd0);
      checkOutput($sformatf("rst_mid_mem_wdata d%0d", k), mwdata[k], 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_no_write d0", mem[0][8], refmem[8]);
    checkOutput("rst_no_write d1", mem[1][8], refmem[8]);
    applyStimulus(1'b0, 3'b011, 64'h40, 64'd0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      rf3 = 3'($urandom_range(0, 7));
      sz  = 1 << rf3[1:0];
      ra  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) ra[2:0] = ra[2:0] & ~3'(sz - 1);
      applyStimulus(1'($urandom_range(0, 1)), rf3, ra, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
